// File: rtl/data_mem_ls_if.sv
// Bus between the core's memory stage and the data memory: load/store
// request, combinational load data, and the store/error status outputs.
interface data_mem_ls_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      addr;
  logic [31:0]      wd;
  logic             we;
  logic [1:0]       ls_ctrl;
  logic [31:0]      rd;
  logic             err_clr;
  logic             misalign_err;
  logic [31:0]      err_addr;
  logic [CNT_W-1:0] store_cnt;
  logic             err_state;

  // Handshake: there is no valid/ready pair. A request is whatever sits on
  // addr/wd/we/ls_ctrl/err_clr at a rising clk edge; rd answers the current
  // addr/ls_ctrl in the same cycle, and status outputs change only at edges
  // or on asynchronous reset.
  modport master (
    output addr, wd, we, ls_ctrl, err_clr,
    input  rd, misalign_err, err_addr, store_cnt, err_state
  );

  modport slave (
    input  addr, wd, we, ls_ctrl, err_clr,
    output rd, misalign_err, err_addr, store_cnt, err_state
  );
endinterface

// File: rtl/data_mem_ls.sv
// Byte-lane data memory for the core's M stage: sized stores, size-extended
// combinational loads, sticky misaligned-store error and a store counter.
module data_mem_ls #(
  parameter int    DEPTH_WORDS = 256,
  parameter string INIT_FILE   = "",
  parameter int    CNT_W       = 16
) (
  input  logic          clk,
  input  logic          reset,
  data_mem_ls_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {
    ST_OK  = 1'b0,
    ST_ERR = 1'b1
  } state_t;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0]    idx;
  logic [1:0]       lane;
  logic [31:0]      word;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic             misalign;
  logic             store_ok;
  logic             mis_store;
  logic [3:0]       be;
  logic [31:0]      wdata;
  logic [31:0]      rd_data;
  logic             unused_addr_bits;

  state_t           state, state_nxt;
  logic [31:0]      err_addr_q, err_addr_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;

  // Upper address bits are deliberately ignored, so the array wraps.
  assign idx              = bus.addr[AW+1:2];
  assign lane             = bus.addr[1:0];
  assign unused_addr_bits = ^bus.addr[31:AW+2];
  assign word             = mem[idx];

  assign ld_byte = word[{lane, 3'b000} +: 8];
  assign ld_half = bus.addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    misalign = 1'b0;
    case (bus.ls_ctrl)
      2'b00:   misalign = (lane != 2'b00);
      2'b10:   misalign = bus.addr[0];
      default: misalign = 1'b0;
    endcase
  end

  assign store_ok  = bus.we & ~misalign;
  assign mis_store = bus.we & misalign;

  always_comb begin
    rd_data = 32'h0;
    if (!misalign) begin
      case (bus.ls_ctrl)
        2'b00:   rd_data = word;
        2'b01:   rd_data = {{24{ld_byte[7]}}, ld_byte};
        2'b10:   rd_data = {{16{ld_half[15]}}, ld_half};
        default: rd_data = {24'h0, ld_byte};
      endcase
    end
  end

  assign bus.rd = rd_data;

  // Narrow stores replicate the data across lanes so each enabled lane can
  // simply take its own slice of wdata.
  always_comb begin
    be    = 4'b0000;
    wdata = bus.wd;
    case (bus.ls_ctrl)
      2'b00: be = 4'b1111;
      2'b10: begin
        be    = bus.addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.wd[15:0]}};
      end
      default: begin
        be    = 4'b0001 << lane;
        wdata = {4{bus.wd[7:0]}};
      end
    endcase
  end

  // Array has no reset; a store coincident with reset is suppressed.
  always_ff @(posedge clk) begin
    if (reset && store_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_OK;
      err_addr_q <= 32'h0;
      cnt_q      <= '0;
    end else begin
      state      <= state_nxt;
      err_addr_q <= err_addr_nxt;
      cnt_q      <= cnt_nxt;
    end
  end

  // A misaligned store beats err_clr in the same cycle; otherwise the first
  // error address is kept until cleared.
  always_comb begin
    state_nxt    = state;
    err_addr_nxt = err_addr_q;
    cnt_nxt      = cnt_q;
    case (state)
      ST_OK: begin
        if (mis_store) begin
          state_nxt    = ST_ERR;
          err_addr_nxt = bus.addr;
        end else if (bus.err_clr) begin
          err_addr_nxt = 32'h0;
        end
      end
      ST_ERR: begin
        if (mis_store) begin
          if (bus.err_clr) err_addr_nxt = bus.addr;
        end else if (bus.err_clr) begin
          state_nxt    = ST_OK;
          err_addr_nxt = 32'h0;
        end
      end
      default: begin
        state_nxt    = ST_OK;
        err_addr_nxt = 32'h0;
      end
    endcase
    if (store_ok && (cnt_q != {CNT_W{1'b1}})) cnt_nxt = cnt_q + CNT_W'(1);
  end

  assign bus.misalign_err = (state == ST_ERR);
  assign bus.err_addr     = err_addr_q;
  assign bus.store_cnt    = cnt_q;
  assign bus.err_state    = state;
endmodule
